// File: rtl/ahb_decode_ctrl_pkg.sv
// Shared encodings for the AHB-Lite decoder and its default slave.
// Bus transfer types, response codes, data-phase select and default-slave state.
package ahb_dec_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        SEL_ROM = 2'd0,
        SEL_RAM = 2'd1,
        SEL_DEF = 2'd2
    } dp_sel_e;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

endpackage

// File: rtl/ahb_decode_ctrl_default_slave.sv
// Default slave: two-cycle ERROR response for active transfers to unmapped addresses.
// Optional saturating error counter built when AHB_DECODE_ERR_CNT_EN is defined.
module ahb_default_slave
    import ahb_dec_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        accept,
    input  logic        err_req,
    input  logic        dp_act,
    output logic        hready,
    output logic        hresp,
    output logic [15:0] err_count
);

    ds_state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // dp_act is always set in ERR1/ERR2; gating keeps an idle data phase OKAY regardless.
    always_comb begin
        state_d = state_q;
        hready  = 1'b1;
        hresp   = HRESP_OKAY;
        case (state_q)
            DS_IDLE: begin
                if (accept && err_req) state_d = DS_ERR1;
            end
            DS_ERR1: begin
                hready  = 1'b0;
                hresp   = dp_act ? HRESP_ERROR : HRESP_OKAY;
                state_d = DS_ERR2;
            end
            DS_ERR2: begin
                hresp   = dp_act ? HRESP_ERROR : HRESP_OKAY;
                state_d = (accept && err_req) ? DS_ERR1 : DS_IDLE;
            end
            default: state_d = DS_IDLE;
        endcase
    end

`ifdef AHB_DECODE_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (state_d == DS_ERR1 && state_q != DS_ERR1 && err_cnt_q != 16'hFFFF)
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 16'h0000;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 16'h0000;
`endif

endmodule

// File: rtl/ahb_decode_ctrl.sv
// AHB-Lite address decoder and response controller for a ROM/RAM slave pair.
// Optional decode-error counter enabled by AHB_DECODE_ERR_CNT_EN.
module ahb_decode_ctrl
    import ahb_dec_pkg::*;
#(
    parameter logic [31:0] ROM_BASE      = 32'h0000_0000,
    parameter int          ROM_ADDR_BITS = 12,
    parameter logic [31:0] RAM_BASE      = 32'h2000_0000,
    parameter int          RAM_ADDR_BITS = 12
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HREADY_MUX,
    input  logic        HRESP_MUX,
    output logic        HSEL_ROM,
    output logic        HSEL_RAM,
    output logic        mux_select,
    output logic        HREADY,
    output logic        HRESP,
    output logic [15:0] err_count
);

    logic    rom_match, ram_match;
    dp_sel_e addr_sel;
    dp_sel_e dp_sel_q, dp_sel_d;
    logic    dp_act_q, dp_act_d;
    logic    mux_select_q, mux_select_d;
    logic    ds_hready, ds_hresp;
    logic    unused_bits;

    assign rom_match = (HADDR[31:ROM_ADDR_BITS] == ROM_BASE[31:ROM_ADDR_BITS]);
    assign ram_match = (HADDR[31:RAM_ADDR_BITS] == RAM_BASE[31:RAM_ADDR_BITS]);

    // ROM takes priority where the two regions overlap.
    assign HSEL_ROM = rom_match;
    assign HSEL_RAM = ram_match && !rom_match;

    assign addr_sel = rom_match ? SEL_ROM : (ram_match ? SEL_RAM : SEL_DEF);
    assign unused_bits = ^{HADDR, HTRANS[0]};

    always_comb begin
        dp_sel_d     = dp_sel_q;
        dp_act_d     = dp_act_q;
        mux_select_d = mux_select_q;
        if (HREADY) begin
            dp_sel_d = addr_sel;
            dp_act_d = HTRANS[1];
            if (addr_sel == SEL_ROM) mux_select_d = 1'b0;
            else if (addr_sel == SEL_RAM) mux_select_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_sel_q     <= SEL_DEF;
            dp_act_q     <= 1'b0;
            mux_select_q <= 1'b0;
        end else begin
            dp_sel_q     <= dp_sel_d;
            dp_act_q     <= dp_act_d;
            mux_select_q <= mux_select_d;
        end
    end

    assign mux_select = mux_select_q;

    ahb_default_slave u_def (
        .clk       (HCLK),
        .rst       (HRESET),
        .accept    (HREADY),
        .err_req   ((addr_sel == SEL_DEF) && HTRANS[1]),
        .dp_act    (dp_act_q),
        .hready    (ds_hready),
        .hresp     (ds_hresp),
        .err_count (err_count)
    );

    assign HREADY = (dp_sel_q == SEL_DEF) ? ds_hready : HREADY_MUX;
    assign HRESP  = (dp_sel_q == SEL_DEF) ? ds_hresp  : HRESP_MUX;

endmodule
